hd44780_bus_writer: RTL and testbench



---
 rtl/hd44780_bus_writer.sv | 189 ++++++++++++++++++
 tb/tb_hd44780_bus_writer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_bus_writer.sv
// HD44780 write engine: takes one RS+byte request, drives RS/RW/E/DB with programmable
// setup / pulse / hold / cycle timing (8- or 4-bit bus), then waits out the execution time.
module hd44780_bus_writer #(
  parameter int BUS_WIDTH   = 8,
  parameter int T_AS        = 1,
  parameter int T_PW        = 3,
  parameter int T_H         = 1,
  parameter int T_CYC       = 6,
  parameter int T_EXEC      = 444,
  parameter int T_EXEC_LONG = 18240
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_rs,
  input  logic [7:0]           i_data,
  input  logic                 i_long,
  output logic                 o_done,
  output logic                 o_lcd_rs,
  output logic                 o_lcd_rw,
  output logic                 o_lcd_e,
  output logic [BUS_WIDTH-1:0] o_lcd_db
);

  localparam int CMAX  = (T_EXEC_LONG > T_CYC) ? T_EXEC_LONG : T_CYC;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int T_BIT = T_AS + T_PW + T_H;
  // Extra idle cycles between nibbles so E rises stay at least T_CYC apart.
  localparam int G     = (T_CYC > T_BIT) ? (T_CYC - T_BIT) : 0;

  localparam logic [CW-1:0] AS_M1    = CW'(T_AS - 1);
  localparam logic [CW-1:0] PW_M1    = CW'(T_PW - 1);
  localparam logic [CW-1:0] H_M1     = CW'(T_H - 1);
  localparam logic [CW-1:0] GAP_M1   = CW'((G > 0) ? (G - 1) : 0);
  localparam logic [CW-1:0] EXEC_M1  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] EXECL_M1 = CW'(T_EXEC_LONG - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    GAP,
    EXEC_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rs_q, rs_d;
  logic [3:0]           lo_q, lo_d;
  logic                 long_q, long_d;
  logic                 nib_hi_q, nib_hi_d;
  logic                 e_q, e_d;
  logic [BUS_WIDTH-1:0] db_q, db_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rs_d     = rs_q;
    lo_d     = lo_q;
    long_d   = long_q;
    nib_hi_d = nib_hi_q;
    e_d      = e_q;
    db_d     = db_q;
    ready_d  = ready_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d  = SETUP;
          cnt_d    = AS_M1;
          rs_d     = i_rs;
          lo_d     = i_data[3:0];
          long_d   = i_long;
          ready_d  = 1'b0;
          nib_hi_d = (BUS_WIDTH == 4);
          if (BUS_WIDTH == 8) db_d = BUS_WIDTH'(i_data);
          else                db_d = BUS_WIDTH'(i_data[7:4]);
        end
      end

      SETUP: begin
        if (cnt_q == '0) begin
          state_d = E_HIGH;
          cnt_d   = PW_M1;
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      E_HIGH: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = H_M1;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          if (nib_hi_q) begin
            nib_hi_d = 1'b0;
            if (G > 0) begin
              state_d = GAP;
              cnt_d   = GAP_M1;
            end else begin
              state_d = SETUP;
              cnt_d   = AS_M1;
              db_d    = BUS_WIDTH'(lo_q);
            end
          end else begin
            state_d = EXEC_WAIT;
            cnt_d   = long_q ? EXECL_M1 : EXEC_M1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      GAP: begin
        if (cnt_q == '0) begin
          state_d = SETUP;
          cnt_d   = AS_M1;
          db_d    = BUS_WIDTH'(lo_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      EXEC_WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        e_d     = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rs_q     <= 1'b0;
      lo_q     <= 4'h0;
      long_q   <= 1'b0;
      nib_hi_q <= 1'b0;
      e_q      <= 1'b0;
      db_q     <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      lo_q     <= lo_d;
      long_q   <= long_d;
      nib_hi_q <= nib_hi_d;
      e_q      <= e_d;
      db_q     <= db_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_done   = done_q;
  assign o_lcd_rs = rs_q;
  assign o_lcd_rw = 1'b0;
  assign o_lcd_e  = e_q;
  assign o_lcd_db = db_q;

endmodule

// File: tb/tb_hd44780_bus_writer.sv
// Bench for hd44780_bus_writer: three instances (8-bit default, 4-bit default, 4-bit custom
// timing) share one request stream; each is compared every cycle to a timeline model.
module tb_hd44780_bus_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, valid, rs, long_i;
  logic [7:0] data;
  logic [2:0] rdy, dn, le, lrs, lrw;
  logic [7:0] db8;
  logic [3:0] db4a, db4c;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  localparam int P_BW[3]  = '{8, 4, 4};
  localparam int P_AS[3]  = '{1, 1, 2};
  localparam int P_PW[3]  = '{3, 3, 2};
  localparam int P_H[3]   = '{1, 1, 2};
  localparam int P_CY[3]  = '{6, 6, 10};
  localparam int P_EX[3]  = '{444, 444, 50};
  localparam int P_EXL[3] = '{18240, 18240, 120};

  hd44780_bus_writer u8 (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .o_ready(rdy[0]), .i_rs(rs), .i_data(data),
    .i_long(long_i), .o_done(dn[0]), .o_lcd_rs(lrs[0]), .o_lcd_rw(lrw[0]), .o_lcd_e(le[0]),
    .o_lcd_db(db8));

  hd44780_bus_writer #(.BUS_WIDTH(4)) u4 (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .o_ready(rdy[1]), .i_rs(rs), .i_data(data),
    .i_long(long_i), .o_done(dn[1]), .o_lcd_rs(lrs[1]), .o_lcd_rw(lrw[1]), .o_lcd_e(le[1]),
    .o_lcd_db(db4a));

  hd44780_bus_writer #(.BUS_WIDTH(4), .T_AS(2), .T_PW(2), .T_H(2), .T_CYC(10), .T_EXEC(50),
                       .T_EXEC_LONG(120)) uc (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .o_ready(rdy[2]), .i_rs(rs), .i_data(data),
    .i_long(long_i), .o_done(dn[2]), .o_lcd_rs(lrs[2]), .o_lcd_rw(lrw[2]), .o_lcd_e(le[2]),
    .o_lcd_db(db4c));

  // Reference: each byte is a fixed timeline relative to its accept edge.
  logic       m_busy[3], m_rs[3], m_long[3], m_e[3], m_done[3];
  logic [7:0] m_data[3], m_db[3];
  int         m_k[3];

  function automatic int spacing(int d);
    int b = P_AS[d] + P_PW[d] + P_H[d];
    return (P_CY[d] > b) ? P_CY[d] : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 3; d++) begin
      int t, n, s, tend;
      m_done[d] = 1'b0;
      m_e[d]    = 1'b0;
      if (reset) begin
        m_busy[d] = 1'b0;
        m_rs[d]   = 1'b0;
        m_db[d]   = 8'h00;
      end else begin
        if (!m_busy[d] && valid) begin
          m_busy[d] = 1'b1; m_k[d] = cyc; m_rs[d] = rs; m_data[d] = data; m_long[d] = long_i;
        end
        if (m_busy[d]) begin
          t    = cyc - m_k[d];
          n    = (P_BW[d] == 4) ? 2 : 1;
          s    = spacing(d);
          tend = (n - 1) * s + P_AS[d] + P_PW[d] + P_H[d] + (m_long[d] ? P_EXL[d] : P_EX[d]);
          for (int j = 0; j < n; j++)
            if (t >= j * s + P_AS[d] && t < j * s + P_AS[d] + P_PW[d]) m_e[d] = 1'b1;
          if (n == 1)      m_db[d] = m_data[d];
          else if (t >= s) m_db[d] = {4'h0, m_data[d][3:0]};
          else             m_db[d] = {4'h0, m_data[d][7:4]};
          if (t == tend) begin
            m_busy[d] = 1'b0;
            m_done[d] = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  function automatic logic [38:0] obs();
    return {rdy[0], dn[0], le[0], lrs[0], lrw[0], db8,
            rdy[1], dn[1], le[1], lrs[1], lrw[1], 4'h0, db4a,
            rdy[2], dn[2], le[2], lrs[2], lrw[2], 4'h0, db4c};
  endfunction

  function automatic logic [38:0] expv();
    return {~m_busy[0], m_done[0], m_e[0], m_rs[0], 1'b0, m_db[0],
            ~m_busy[1], m_done[1], m_e[1], m_rs[1], 1'b0, m_db[1],
            ~m_busy[2], m_done[2], m_e[2], m_rs[2], 1'b0, m_db[2]};
  endfunction

  function automatic bit all_idle();
    return !(m_busy[0] || m_busy[1] || m_busy[2]);
  endfunction

  task automatic test_reset();
    reset = 1'b1; valid = 1'b1; rs = 1'b1; data = 8'hFF; long_i = 1'b0;
    tick(); tick();
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs(), expv());
    end
    checks++;
    if ({rdy, dn, le, lrw, lrs, db8, db4a, db4c} !== {3'b111, 12'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset_values got=%b exp=111 then zeros", {rdy, dn, le, lrw, lrs, db8, db4a, db4c});
    end
    valid = 1'b0; reset = 1'b0;
  endtask

  task automatic test_8bit();
    int k, d8 = -1, d4 = -1, rise = -1, ehi = 0;
    valid = 1'b1; rs = 1'b1; data = 8'h41; long_i = 1'b0;
    tick(); k = cyc;
    valid = 1'b0; rs = 1'($urandom); data = 8'($urandom);
    checks++;
    if ({lrs[0], db8, db4a} !== {1'b1, 8'h41, 4'h4}) begin
      failures++; $display("FAIL accept_8bit got=%h exp=%h", {lrs[0], db8, db4a}, {1'b1, 8'h41, 4'h4});
    end
    for (int i = 0; i < 600; i++) begin
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL byte_8bit cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (le[0]) begin ehi++; if (rise < 0) rise = cyc - k; end
      if (dn[0]) d8 = cyc - k;
      if (dn[1]) d4 = cyc - k;
      if (all_idle()) break;
      tick();
    end
    checks++;
    if (!all_idle()) begin failures++; $display("FAIL byte_8bit_timeout got=busy exp=idle"); end
    checks++;
    if (d8 != 449 || d4 != 455) begin
      failures++; $display("FAIL done_edges got=%0d/%0d exp=449/455", d8, d4);
    end
    checks++;
    if (rise != 1 || ehi != 3) begin
      failures++; $display("FAIL e_pulse_8bit got rise=%0d width=%0d exp rise=1 width=3", rise, ehi);
    end
  endtask

  task automatic test_4bit();
    int k, d4 = -1;
    logic [7:0] dv;
    dv = 8'($urandom);
    valid = 1'b1; rs = 1'($urandom); data = dv; long_i = 1'b0;
    tick(); k = cyc;
    valid = 1'b0; data = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL byte_4bit cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (cyc - k == 5 || cyc - k == 6) begin
        checks++;
        if (db4a !== ((cyc - k == 5) ? dv[7:4] : dv[3:0])) begin
          failures++; $display("FAIL nibble_order t=%0d got=%h data=%h", cyc - k, db4a, dv);
        end
      end
      if (dn[1]) d4 = cyc - k;
      if (all_idle()) break;
      tick();
    end
    checks++;
    if (!all_idle() || d4 != 455) begin
      failures++; $display("FAIL done_4bit got=%0d exp=455", d4);
    end
  endtask

  task automatic test_long();
    int k, d8 = -1, d4 = -1, late_e = 0;
    valid = 1'b1; rs = 1'b0; data = 8'h01; long_i = 1'b1;
    tick(); k = cyc;
    valid = 1'b0; long_i = 1'b0; data = 8'($urandom);
    for (int i = 0; i < 18400; i++) begin
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL long_wait cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (le[0] && cyc - k > 5) late_e++;
      if (dn[0]) d8 = cyc - k;
      if (dn[1]) d4 = cyc - k;
      if (all_idle()) break;
      tick();
    end
    checks++;
    if (!all_idle() || d8 != 18245 || d4 != 18251 || late_e != 0) begin
      failures++; $display("FAIL long_done got=%0d/%0d e_late=%0d exp=18245/18251 e_late=0", d8, d4, late_e);
    end
  endtask

  task automatic test_hold_valid();
    logic pd8; logic [7:0] pdata; logic prs;
    int hits = 0;
    valid = 1'b1; long_i = 1'b0; rs = 1'($urandom); data = 8'($urandom);
    for (int i = 0; i < 1400; i++) begin
      pd8 = dn[0]; pdata = data; prs = rs;
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL held_valid cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (pd8) begin
        hits++; checks++;
        if ({rdy[0], lrs[0], db8} !== {1'b0, prs, pdata}) begin
          failures++; $display("FAIL reaccept cyc=%0d got=%h exp=%h", cyc, {rdy[0], lrs[0], db8}, {1'b0, prs, pdata});
        end
      end
      data = 8'($urandom); rs = 1'($urandom);
    end
    valid = 1'b0;
    checks++;
    if (hits < 2) begin failures++; $display("FAIL reaccept_count got=%0d exp>=2", hits); end
    for (int i = 0; i < 600 && !all_idle(); i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL held_drain cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    checks++;
    if (!all_idle()) begin failures++; $display("FAIL held_drain_timeout got=busy exp=idle"); end
  endtask

  task automatic test_midreset();
    int k, spurious = 0, d8 = -1;
    valid = 1'b1; rs = 1'b1; data = 8'($urandom); long_i = 1'b0;
    tick(); valid = 1'b0;
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    checks++;
    if ({le, rdy, dn, lrs, db8, db4a, db4c} !== {3'b000, 3'b111, 22'h0}) begin
      failures++; $display("FAIL midreset got=%b exp=000111 then zeros", {le, rdy, dn, lrs, db8, db4a, db4c});
    end
    for (int i = 0; i < 500; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (dn != 3'b000) spurious++;
    end
    checks++;
    if (spurious != 0) begin failures++; $display("FAIL no_done_after_reset got=%0d exp=0", spurious); end
    valid = 1'b1; rs = 1'($urandom); data = 8'($urandom);
    tick(); k = cyc; valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL fresh_req cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      if (dn[0]) d8 = cyc - k;
      if (all_idle()) break;
      tick();
    end
    checks++;
    if (!all_idle() || d8 != 449) begin failures++; $display("FAIL fresh_done got=%0d exp=449", d8); end
  endtask

  task automatic test_custom_timing();
    int k, last_chg = -100, fall = -100;
    int rises[$];
    logic [4:0] sig, psig;
    logic pe;
    psig = {lrs[2], db4c}; pe = le[2];
    valid = 1'b1; rs = 1'($urandom); data = 8'($urandom); long_i = 1'b0;
    tick(); k = cyc; valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL custom cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
      sig = {lrs[2], db4c};
      if (le[2] && !pe) begin
        rises.push_back(cyc - k); checks++;
        if (cyc - last_chg < 2) begin
          failures++; $display("FAIL setup_window got=%0d exp>=2", cyc - last_chg);
        end
      end
      if (!le[2] && pe) fall = cyc;
      if (sig !== psig) begin
        checks++;
        if (le[2] || cyc - fall < 2) begin
          failures++; $display("FAIL hold_window cyc=%0d e=%b since_fall=%0d exp e=0 >=2", cyc, le[2], cyc - fall);
        end
        last_chg = cyc;
      end
      psig = sig; pe = le[2];
      if (all_idle()) break;
      tick();
    end
    checks++;
    if (rises.size() != 2) begin
      failures++; $display("FAIL custom_rises got=%0d exp=2", rises.size());
    end else if (rises[0] != 2 || rises[1] != 12) begin
      failures++; $display("FAIL custom_rise_edges got=%0d,%0d exp=2,12", rises[0], rises[1]);
    end
  endtask

  initial begin
    test_reset();
    test_8bit();
    test_4bit();
    test_long();
    test_hold_valid();
    test_midreset();
    test_custom_timing();
    for (int r = 0; r < 3; r++) test_4bit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
